// File: rtl/mod_not_pipe_pkg.sv
// mod_not_pkg: shared constants for the mod_not_pipe block.
//   MOD_NOT_WIDTH_DEF : default data width
//   MOD_NOT_DEPTH_DEF : default number of register stages
//   MOD_NOT_CNT_W     : width of the optional output-transfer counter
package mod_not_pkg;
    localparam int MOD_NOT_WIDTH_DEF = 8;
    localparam int MOD_NOT_DEPTH_DEF = 2;
    localparam int MOD_NOT_CNT_W     = 16;
endpackage

// File: rtl/mod_not_pipe_if.sv
// mod_not_pipe_if: input and output streams of mod_not_pipe.
//   x, inv_mask, in_valid : input word, per-bit invert select, word valid
//   in_ready              : block accepts the input word this cycle
//   y, out_valid          : result word and its valid
//   out_ready             : downstream accepts y
// Handshake: a word moves on a rising edge where valid and ready are both 1;
// a producer holds valid and data stable until that edge, and valid never
// depends on ready.
// Modports: master = the side feeding x and consuming y; slave = the block.
interface mod_not_pipe_if
    import mod_not_pkg::*;
#(
    parameter int WIDTH = MOD_NOT_WIDTH_DEF
);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] inv_mask;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output x, inv_mask, in_valid, out_ready,
        input  in_ready, y, out_valid
    );

    modport slave (
        input  x, inv_mask, in_valid, out_ready,
        output in_ready, y, out_valid
    );
endinterface

// File: rtl/mod_not_pipe_stage.sv
// mod_not_stage: one register stage of the mod_not_pipe chain.
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : stage takes src_valid/src_data this cycle
//   src_valid, src_data : word offered by the previous stage (or the input)
//   valid, data         : contents of this stage
module mod_not_stage
    import mod_not_pkg::*;
#(
    parameter int WIDTH = MOD_NOT_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= src_valid;
            // A bubble moving in leaves the old data untouched so y does
            // not toggle on meaningless input values.
            if (src_valid) begin
                data <= src_data;
            end
        end
    end
endmodule

// File: rtl/mod_not_pipe.sv
// mod_not_pipe: DEPTH-stage elastic pipeline computing y = x ^ inv_mask.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mod_not_pipe_if.slave (input and output valid/ready streams)
//   xfer_cnt   : output-transfer counter, present only when the macro
//                MOD_NOT_PIPE_CNT_EN is defined
// The XOR is applied on entry to stage 0; later stages copy. Every stage
// loads when empty or when its content leaves in the same cycle, so bubbles
// collapse and DEPTH words are held under full back-pressure.
module mod_not_pipe
    import mod_not_pkg::*;
#(
    parameter int WIDTH = MOD_NOT_WIDTH_DEF,
    parameter int DEPTH = MOD_NOT_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mod_not_pipe_if.slave            bus
`ifdef MOD_NOT_PIPE_CNT_EN
    ,
    output logic [MOD_NOT_CNT_W-1:0] xfer_cnt
`endif
);
    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] stage_load;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic             take;

    // Ready ripples back from out_ready through the valid bits, last stage
    // first; this is the only combinational path through the block.
    always_comb begin
        stage_load = '0;
        take       = bus.out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            stage_load[k] = !stage_valid[k] || take;
            take          = stage_load[k];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            mod_not_stage #(.WIDTH(WIDTH)) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (stage_load[0]),
                .src_valid (bus.in_valid),
                .src_data  (bus.x ^ bus.inv_mask),
                .valid     (stage_valid[0]),
                .data      (stage_data[0])
            );
        end else begin : g_next
            mod_not_stage #(.WIDTH(WIDTH)) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (stage_load[k]),
                .src_valid (stage_valid[k-1]),
                .src_data  (stage_data[k-1]),
                .valid     (stage_valid[k]),
                .data      (stage_data[k])
            );
        end
    end

    assign bus.in_ready  = stage_load[0];
    assign bus.out_valid = stage_valid[DEPTH-1];
    assign bus.y         = stage_data[DEPTH-1];

`ifdef MOD_NOT_PIPE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            xfer_cnt <= xfer_cnt + MOD_NOT_CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_mod_not_pipe.sv
// tb_mod_not_pipe: directed bench for mod_not_pipe. Two instances:
// dut_a (WIDTH=8, DEPTH=2) and dut_b (WIDTH=1, DEPTH=1). Drivers push the
// hand-computed result into a queue when a word is accepted; per-instance
// monitors pop and compare on every output transfer. Define
// MOD_NOT_PIPE_CNT_EN to also exercise the xfer_cnt wrap.
module tb_mod_not_pipe;
    import mod_not_pkg::*;

    localparam int DA = 2;
    localparam int DB = 1;

    // ---------------- clock / reset ----------------
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mod_not_pipe_if #(.WIDTH(8)) a ();
    mod_not_pipe_if #(.WIDTH(1)) b ();

`ifdef MOD_NOT_PIPE_CNT_EN
    logic [MOD_NOT_CNT_W-1:0] xfer_cnt;
`endif

    mod_not_pipe #(.WIDTH(8), .DEPTH(DA)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (a.slave)
`ifdef MOD_NOT_PIPE_CNT_EN
        ,
        .xfer_cnt (xfer_cnt)
`endif
    );

    mod_not_pipe #(.WIDTH(1), .DEPTH(DB)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    // ---------------- scoreboard ----------------
    logic [7:0]  exp_q   [$];
    int unsigned t_q     [$];
    logic [0:0]  exp_b_q [$];
    int unsigned t_b_q   [$];
    bit          lat_chk = 1'b0;
    int          n_cmp   = 0;
    int          n_err   = 0;
    int          n_out_a = 0;
    int          n_out_b = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // Monitors: sample half a cycle after the edge, when outputs are settled.
    always @(negedge clk) begin
        if (rst_n && a.out_valid && a.out_ready) begin
            if (exp_q.size() == 0) begin
                fail_now("y_a unexpected output");
            end else begin
                logic [7:0]  e;
                int unsigned t;
                e = exp_q.pop_front();
                t = t_q.pop_front();
                check("y_a", 64'(a.y), 64'(e));
                if (lat_chk) check("lat_a", 64'(cyc - t), 64'(DA));
            end
            n_out_a++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && b.out_valid && b.out_ready) begin
            if (exp_b_q.size() == 0) begin
                fail_now("y_b unexpected output");
            end else begin
                logic [0:0]  e;
                int unsigned t;
                e = exp_b_q.pop_front();
                t = t_b_q.pop_front();
                check("y_b", 64'(b.y), 64'(e));
                check("lat_b", 64'(cyc - t), 64'(DB));
            end
            n_out_b++;
        end
    end

    // ---------------- drivers ----------------
    // Called one time unit after a rising edge; return at the same phase.
    task automatic send_a(input logic [7:0] xv, input logic [7:0] mv, input logic [7:0] ev);
        a.x        = xv;
        a.inv_mask = mv;
        a.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a.in_ready) begin
                exp_q.push_back(ev);
                t_q.push_back(cyc);
                @(posedge clk);
                #1;
                a.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        a.in_valid = 1'b0;
        fail_now("send_a timeout");
    endtask

    task automatic send_b(input logic xv, input logic mv, input logic ev);
        b.x        = xv;
        b.inv_mask = mv;
        b.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b.in_ready) begin
                exp_b_q.push_back(ev);
                t_b_q.push_back(cyc);
                @(posedge clk);
                #1;
                b.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        b.in_valid = 1'b0;
        fail_now("send_b timeout");
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        exp_q.delete();
        t_q.delete();
        exp_b_q.delete();
        t_b_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int saved;
        a.x = '0; a.inv_mask = '0; a.in_valid = 1'b0; a.out_ready = 1'b1;
        b.x = '0; b.inv_mask = '0; b.in_valid = 1'b0; b.out_ready = 1'b1;

        // Reset state
        #3;
        check("rst y_a", 64'(a.y), 64'h00);
        check("rst out_valid_a", 64'(a.out_valid), 64'd0);
        check("rst y_b", 64'(b.y), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst in_ready_a", 64'(a.in_ready), 64'd1);
        check("rst in_ready_b", 64'(b.in_ready), 64'd1);
        idle(1);

        // NOT pattern, then partial and zero masks, back to back
        lat_chk = 1'b1;
        send_a(8'h00, 8'hFF, 8'hFF);
        send_a(8'hFF, 8'hFF, 8'h00);
        send_a(8'hA5, 8'hFF, 8'h5A);
        send_a(8'hA5, 8'h0F, 8'hAA);
        send_a(8'hA5, 8'h00, 8'hA5);
        idle(5);
        check("drain_a basic", 64'(exp_q.size()), 64'd0);
        check("count_a basic", 64'(n_out_a), 64'd5);

        // Single-bit NOT, DEPTH=1
        send_b(1'b0, 1'b1, 1'b1);
        send_b(1'b1, 1'b1, 1'b0);
        send_b(1'b0, 1'b1, 1'b1);
        send_b(1'b1, 1'b1, 1'b0);
        idle(4);
        check("drain_b", 64'(exp_b_q.size()), 64'd0);
        check("count_b", 64'(n_out_b), 64'd4);

        // Full back-pressure with 5 words offered continuously
        lat_chk = 1'b0;
        saved = n_out_a;
        a.out_ready = 1'b0;
        fork
            begin
                send_a(8'h11, 8'hFF, 8'hEE);
                send_a(8'h22, 8'hFF, 8'hDD);
                send_a(8'h33, 8'hFF, 8'hCC);
                send_a(8'h44, 8'hFF, 8'hBB);
                send_a(8'h55, 8'hFF, 8'hAA);
            end
            begin
                repeat (10) @(posedge clk);
                @(negedge clk);
                check("stall accepted", 64'(exp_q.size()), 64'd2);
                check("stall in_ready", 64'(a.in_ready), 64'd0);
                check("stall out_valid", 64'(a.out_valid), 64'd1);
                check("stall y", 64'(a.y), 64'hEE);
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("stall y stable", 64'(a.y), 64'hEE);
                check("stall out_valid stable", 64'(a.out_valid), 64'd1);
                @(posedge clk);
                #1 a.out_ready = 1'b1;
            end
        join
        idle(6);
        check("drain_a stall", 64'(exp_q.size()), 64'd0);
        check("count_a stall", 64'(n_out_a - saved), 64'd5);

        // Reset mid-stream: two words in flight are discarded
        send_a(8'h01, 8'h00, 8'h01);
        send_a(8'h02, 8'h00, 8'h02);
        #1 rst_n = 1'b0;
        #1;
        check("midrst y", 64'(a.y), 64'h00);
        check("midrst out_valid", 64'(a.out_valid), 64'd0);
        exp_q.delete();
        t_q.delete();
        saved = n_out_a;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("midrst in_ready", 64'(a.in_ready), 64'd1);
        idle(6);
        check("midrst no output", 64'(n_out_a - saved), 64'd0);

`ifdef MOD_NOT_PIPE_CNT_EN
        // Counter wrap: 65537 output transfers from reset leave 1
        do_reset();
        check("cnt reset", 64'(xfer_cnt), 64'd0);
        lat_chk = 1'b1;
        saved = n_out_a;
        for (int i = 0; i < 65537; i++) begin
            send_a(8'(i), 8'hFF, ~8'(i));
        end
        idle(5);
        check("cnt transfers", 64'(n_out_a - saved), 64'd65537);
        check("cnt wrap", 64'(xfer_cnt), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
